imem_fetch_ctrl: RTL

Fetch-side responder to the PC register: takes the current PC, runs a req/ack read transaction to instruction memory, and presents the fetched word to decode. It generates the PC register's advance enable, so the PC moves only after a fetch completes. It also absorbs decode stalls with a one-entry skid buffer and discards in-flight fetches on a branch redirect.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_skid_reg.sv | 54 +++++
 rtl/imem_fetch_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch controller.
// The five fetch states and the default data width / bubble encoding live here.
package fetch_pkg;

    localparam int               FETCH_DATA_W    = 32;
    localparam logic [31:0]      FETCH_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ADV,
        HOLD,
        PARK
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry skid buffer: parks a fetched word and its address while decode stalls.
// Clear wins over load so a redirect always empties the entry.
module fetch_skid_reg
    import fetch_pkg::*;
#(
    parameter int DATA_W = FETCH_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] pc_in,
    output logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] pc,
    output logic              valid
);

    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        data_d  = data_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            data_d  = data_in;
            pc_d    = pc_in;
            valid_d = 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments and reset asynchronously on rst low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign data  = data_q;
    assign pc    = pc_q;
    assign valid = valid_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch controller: runs one req/ack read per PC, presents the word to decode,
// and raises pc_en only after a fetch retires; absorbs decode stalls and redirects.
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                DATA_W    = FETCH_DATA_W,
    parameter logic [DATA_W-1:0] NOP_INSTR = FETCH_NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pc,
    output logic              pc_en,
    input  logic              flush,
    input  logic              hold_d,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic              misalign
);

    fetch_state_e      state_q, state_d;
    logic              req_q, req_d;
    logic              drop_q, drop_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] req_pc_q, req_pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] instr_pc_q, instr_pc_d;
    logic              instr_valid_q, instr_valid_d;
    logic              misalign_q, misalign_d;

    logic              skid_load, skid_clear, skid_valid;
    logic [DATA_W-1:0] skid_data, skid_pc;

    logic              in_issue, pc_misaligned;
    logic [DATA_W-1:0] cur_addr, cur_pc;

    // The first request cycle presents the live PC; later cycles replay the latched copy,
    // which keeps the address stable even after a redirect moves the PC register.
    assign in_issue      = (state_q == ISSUE);
    assign pc_misaligned = (pc[1:0] != 2'b00);
    assign cur_addr      = req_q ? addr_q : {pc[DATA_W-1:2], 2'b00};
    assign cur_pc        = req_q ? req_pc_q : pc;

    assign mem_req  = in_issue && (req_q || !pc_misaligned);
    assign mem_addr = in_issue ? cur_addr : addr_q;
    assign pc_en    = (state_q == ADV) || flush;

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        drop_d        = drop_q;
        addr_d        = addr_q;
        req_pc_d      = req_pc_q;
        misalign_d    = misalign_q;
        instr_pc_d    = instr_pc_q;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;
        instr_d       = hold_d ? instr_q       : NOP_INSTR;
        instr_valid_d = hold_d ? instr_valid_q : 1'b0;

        if (flush) begin
            instr_d       = NOP_INSTR;
            instr_valid_d = 1'b0;
            skid_clear    = 1'b1;
            misalign_d    = 1'b0;
            if (mem_req && !mem_ack) begin
                drop_d   = 1'b1;
                req_d    = 1'b1;
                addr_d   = cur_addr;
                req_pc_d = cur_pc;
            end else begin
                state_d = ISSUE;
                req_d   = 1'b0;
                drop_d  = 1'b0;
            end
        end else begin
            unique case (state_q)
                IDLE: state_d = ISSUE;
                ISSUE: begin
                    if (!mem_req) begin
                        misalign_d = 1'b1;
                        state_d    = PARK;
                    end else if (mem_ack) begin
                        req_d = 1'b0;
                        if (drop_q) begin
                            drop_d = 1'b0;
                        end else if (!hold_d) begin
                            instr_d       = mem_rdata;
                            instr_pc_d    = cur_pc;
                            instr_valid_d = 1'b1;
                            state_d       = ADV;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = HOLD;
                        end
                    end else begin
                        req_d    = 1'b1;
                        addr_d   = cur_addr;
                        req_pc_d = cur_pc;
                    end
                end
                ADV: state_d = ISSUE;
                HOLD: begin
                    if (!hold_d) begin
                        instr_d       = skid_data;
                        instr_pc_d    = skid_pc;
                        instr_valid_d = skid_valid;
                        skid_clear    = 1'b1;
                        state_d       = ADV;
                    end
                end
                PARK: state_d = PARK;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            req_q         <= 1'b0;
            drop_q        <= 1'b0;
            addr_q        <= '0;
            req_pc_q      <= '0;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            drop_q        <= drop_d;
            addr_q        <= addr_d;
            req_pc_q      <= req_pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            misalign_q    <= misalign_d;
        end
    end

    fetch_skid_reg #(.DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .clear   (skid_clear),
        .data_in (mem_rdata),
        .pc_in   (cur_pc),
        .data    (skid_data),
        .pc      (skid_pc),
        .valid   (skid_valid)
    );

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign misalign    = misalign_q;

endmodule
